onchip_memory_arb2: RTL and testbench

//  Parametrised on-chip RAM exposing two Avalon-MM slave ports (s1, s2) over one

---
 rtl/onchip_memory_arb2_if.sv | 27 ++
 rtl/onchip_memory_arb2.sv | 136 +++++++++++++
 tb/tb_onchip_memory_arb2.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_memory_arb2_if.sv
// rtl/onchip_memory_arb2_if.sv - one Avalon-MM slave port of the dual-port arbitrated on-chip RAM
interface onchip_memory_arb2_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) ();
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arb2.sv
// rtl/onchip_memory_arb2.sv - single-port RAM shared by two arbitrated Avalon-MM slave ports
module onchip_memory_arb2 #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int DEPTH        = 10024,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0
) (
    input logic              clk,
    input logic              reset,
    onchip_memory_arb2_if.slave s1,
    onchip_memory_arb2_if.slave s2
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic              req1, req2;
    logic              gnt1, gnt2;
    logic              last_s2_q;

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_rd, acc_wr;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] acc_wd;
    logic              acc_in_range;
    logic [IDX_W-1:0]  acc_idx;
    logic              wr_en, rd_en;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [1:0]        v1_q;
    logic              oob1_q;
    logic [DATA_W-1:0] data1;
    logic [1:0]        out_v;
    logic [DATA_W-1:0] out_d;

    assign req1 = s1.chipselect & (s1.read | s1.write);
    assign req2 = s2.chipselect & (s2.read | s2.write);

    // Single grant per cycle; contention resolved by fixed priority or by the last-grant pointer
    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (req1 && req2) begin
            if ((FIXED_PRIO != 0) || last_s2_q) gnt1 = 1'b1;
            else                                gnt2 = 1'b1;
        end else begin
            gnt1 = req1;
            gnt2 = req2;
        end
    end

    assign s1.waitrequest = req1 & ~gnt1;
    assign s2.waitrequest = req2 & ~gnt2;

    // Last-grant pointer; reset to s2 so s1 wins the first contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            last_s2_q <= 1'b1;
        else if (gnt1 | gnt2) last_s2_q <= gnt2;
    end

    // Route the granted port's request onto the shared array
    always_comb begin
        acc_addr = s1.address;
        acc_rd   = s1.read;
        acc_wr   = s1.write;
        acc_be   = s1.byteenable;
        acc_wd   = s1.writedata;
        if (gnt2) begin
            acc_addr = s2.address;
            acc_rd   = s2.read;
            acc_wr   = s2.write;
            acc_be   = s2.byteenable;
            acc_wd   = s2.writedata;
        end
    end

    assign acc_in_range = {1'b0, acc_addr} < DEPTH_LIM;
    assign acc_idx      = acc_addr[IDX_W-1:0];
    // A combined read+write is treated purely as a write
    assign wr_en = (gnt1 | gnt2) & acc_wr & acc_in_range & ~reset;
    assign rd_en = (gnt1 | gnt2) & acc_rd & ~acc_wr;

    // Byte-lane writes and registered read of the array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_wd[b*8 +: 8];
            end
        end
        if (rd_en && acc_in_range) ram_q <= mem[acc_idx];
    end

    // First return stage: per-port valid tag plus out-of-range flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 2'b00;
            oob1_q <= 1'b0;
        end else begin
            v1_q   <= {rd_en & gnt2, rd_en & gnt1};
            oob1_q <= rd_en & ~acc_in_range;
        end
    end

    assign data1 = oob1_q ? '0 : ram_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [1:0]        v2_q;
            logic [DATA_W-1:0] d2_q;

            // Second return stage for the two-cycle latency build
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2_q <= 2'b00;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    d2_q <= data1;
                end
            end

            assign out_v = v2_q;
            assign out_d = d2_q;
        end else begin : g_lat1
            assign out_v = v1_q;
            assign out_d = data1;
        end
    endgenerate

    assign s1.readdatavalid = out_v[0];
    assign s2.readdatavalid = out_v[1];
    assign s1.readdata      = out_v[0] ? out_d : '0;
    assign s2.readdata      = out_v[1] ? out_d : '0;
endmodule

// File: tb/tb_onchip_memory_arb2.sv
// tb/tb_onchip_memory_arb2.sv - directed-vector bench for onchip_memory_arb2
module tb_onchip_memory_arb2;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    onchip_memory_arb2_if #(.DATA_W(32), .ADDR_W(14)) a1 ();
    onchip_memory_arb2_if #(.DATA_W(32), .ADDR_W(14)) a2 ();
    onchip_memory_arb2_if #(.DATA_W(32), .ADDR_W(14)) b1 ();
    onchip_memory_arb2_if #(.DATA_W(32), .ADDR_W(14)) b2 ();

    onchip_memory_arb2 #(.DATA_W(32), .ADDR_W(14), .DEPTH(10024), .READ_LATENCY(1), .FIXED_PRIO(0))
        dut_a (.clk(clk), .reset(rst_a), .s1(a1.slave), .s2(a2.slave));
    onchip_memory_arb2 #(.DATA_W(32), .ADDR_W(14), .DEPTH(10024), .READ_LATENCY(2), .FIXED_PRIO(1))
        dut_b (.clk(clk), .reset(rst_b), .s1(b1.slave), .s2(b2.slave));

    task automatic drive(input int d, input int p, input logic cs, input logic rd, input logic wr,
                         input logic [13:0] addr, input logic [3:0] be, input logic [31:0] wd);
        if (d == 0 && p == 1) begin
            a1.chipselect = cs; a1.read = rd; a1.write = wr;
            a1.address = addr; a1.byteenable = be; a1.writedata = wd;
        end else if (d == 0) begin
            a2.chipselect = cs; a2.read = rd; a2.write = wr;
            a2.address = addr; a2.byteenable = be; a2.writedata = wd;
        end else if (p == 1) begin
            b1.chipselect = cs; b1.read = rd; b1.write = wr;
            b1.address = addr; b1.byteenable = be; b1.writedata = wd;
        end else begin
            b2.chipselect = cs; b2.read = rd; b2.write = wr;
            b2.address = addr; b2.byteenable = be; b2.writedata = wd;
        end
    endtask

    task automatic idle(input int d, input int p);
        drive(d, p, 1'b0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    endtask

    task automatic sample(input int d, input int p, output logic w, output logic v, output logic [31:0] rdata);
        if (d == 0 && p == 1)  begin w = a1.waitrequest; v = a1.readdatavalid; rdata = a1.readdata; end
        else if (d == 0)       begin w = a2.waitrequest; v = a2.readdatavalid; rdata = a2.readdata; end
        else if (p == 1)       begin w = b1.waitrequest; v = b1.readdatavalid; rdata = b1.readdata; end
        else                   begin w = b2.waitrequest; v = b2.readdatavalid; rdata = b2.readdata; end
    endtask

    task automatic wait_grant(input int d, input int p, output logic granted);
        logic w, v;
        logic [31:0] rdata;
        granted = 1'b0;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            sample(d, p, w, v, rdata);
            if (!w) granted = 1'b1;
            @(posedge clk);
            #1;
        end
        idle(d, p);
    endtask

    task automatic bus_write(input int d, input int p, input logic [13:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output logic granted);
        drive(d, p, 1'b1, 1'b0, 1'b1, addr, be, wd);
        wait_grant(d, p, granted);
    endtask

    task automatic bus_read(input int d, input int p, input logic [13:0] addr,
                            output logic [31:0] rdata, output int lat);
        logic g, w, v;
        logic [31:0] rd;
        rdata = 32'h0;
        drive(d, p, 1'b1, 1'b1, 1'b0, addr, 4'hF, 32'h0);
        wait_grant(d, p, g);
        if (!g) begin
            lat = -1;
        end else begin
            lat = -2;
            for (int c = 1; c <= 8 && lat == -2; c++) begin
                @(negedge clk);
                sample(d, p, w, v, rd);
                if (v) begin
                    lat   = c;
                    rdata = rd;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle(0, 1); idle(0, 2); idle(1, 1); idle(1, 2);
        repeat (2) @(negedge clk);
        vectors++; if (a1.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_a1_valid: got %b expected 0", a1.readdatavalid); end
        vectors++; if (a1.readdata !== 32'h0) begin errors++; $display("FAIL reset_a1_rdata: got %h expected 0", a1.readdata); end
        vectors++; if (a2.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_a2_valid: got %b expected 0", a2.readdatavalid); end
        vectors++; if (a2.readdata !== 32'h0) begin errors++; $display("FAIL reset_a2_rdata: got %h expected 0", a2.readdata); end
        vectors++; if ({a1.waitrequest, a2.waitrequest} !== 2'b00) begin errors++; $display("FAIL reset_a_wait: got %b expected 00", {a1.waitrequest, a2.waitrequest}); end
        vectors++; if ({b1.readdatavalid, b2.readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_b_valid: got %b expected 00", {b1.readdatavalid, b2.readdatavalid}); end
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_write_read;
        logic g;
        logic [31:0] d;
        int lat;
        bus_write(0, 1, 14'h10, 32'hDEADBEEF, 4'hF, g);
        vectors++; if (g !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b expected 1", g); end
        bus_read(0, 1, 14'h10, d, lat);
        vectors++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_s1_data: got %h expected deadbeef", d); end
        vectors++; if (lat !== 1) begin errors++; $display("FAIL rd_s1_latency: got %0d expected 1", lat); end
        bus_read(0, 2, 14'h10, d, lat);
        vectors++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_s2_data: got %h expected deadbeef", d); end
        vectors++; if (lat !== 1) begin errors++; $display("FAIL rd_s2_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_byteenable;
        logic g, w, v;
        logic [31:0] d, rd;
        int lat, cnt;
        bus_write(0, 2, 14'd5, 32'hAABBCCDD, 4'hF, g);
        bus_write(0, 2, 14'd5, 32'h11223344, 4'b0101, g);
        bus_read(0, 1, 14'd5, d, lat);
        vectors++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge: got %h expected aa22cc44", d); end
        bus_write(0, 1, 14'd5, 32'hFFFFFFFF, 4'h0, g);
        vectors++; if (g !== 1'b1) begin errors++; $display("FAIL be0_grant: got %b expected 1", g); end
        bus_read(0, 1, 14'd5, d, lat);
        vectors++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL be0_noop: got %h expected aa22cc44", d); end
        drive(0, 1, 1'b1, 1'b1, 1'b1, 14'd5, 4'hF, 32'h55555555);
        wait_grant(0, 1, g);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(0, 1, w, v, rd);
            if (v) cnt++;
        end
        @(posedge clk);
        #1;
        vectors++; if (cnt !== 0) begin errors++; $display("FAIL rdwr_no_valid: got %0d pulses expected 0", cnt); end
        bus_read(0, 1, 14'd5, d, lat);
        vectors++; if (d !== 32'h55555555) begin errors++; $display("FAIL rdwr_as_write: got %h expected 55555555", d); end
    endtask

    task automatic test_round_robin;
        logic w1, v1, w2, v2;
        logic [31:0] r1, r2;
        int c1, c2;
        @(posedge clk); #1; rst_a = 1'b1;
        @(posedge clk); #1; rst_a = 1'b0;
        drive(0, 1, 1'b1, 1'b1, 1'b0, 14'h10, 4'hF, 32'h0);
        drive(0, 2, 1'b1, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            sample(0, 1, w1, v1, r1);
            sample(0, 2, w2, v2, r2);
            if (i < 6) begin
                vectors++; if (w1 !== logic'(i % 2 == 1)) begin errors++; $display("FAIL rr_s1_wait[%0d]: got %b expected %b", i, w1, i % 2 == 1); end
                vectors++; if (w2 !== logic'(i % 2 == 0)) begin errors++; $display("FAIL rr_s2_wait[%0d]: got %b expected %b", i, w2, i % 2 == 0); end
            end
            if (v1) begin
                c1++;
                vectors++; if (r1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_s1_data[%0d]: got %h expected deadbeef", i, r1); end
            end
            if (v2) begin
                c2++;
                vectors++; if (r2 !== 32'h55555555) begin errors++; $display("FAIL rr_s2_data[%0d]: got %h expected 55555555", i, r2); end
            end
            @(posedge clk);
            #1;
            if (i == 5) begin
                idle(0, 1);
                idle(0, 2);
            end
        end
        vectors++; if (c1 !== 3) begin errors++; $display("FAIL rr_s1_count: got %0d expected 3", c1); end
        vectors++; if (c2 !== 3) begin errors++; $display("FAIL rr_s2_count: got %0d expected 3", c2); end
    endtask

    task automatic test_out_of_range;
        logic g;
        logic [31:0] d;
        int lat;
        bus_write(0, 1, 14'd0, 32'h01020304, 4'hF, g);
        bus_write(0, 2, 14'd10023, 32'h0A0B0C0D, 4'hF, g);
        bus_write(0, 1, 14'd10024, 32'hFFFFFFFF, 4'hF, g);
        vectors++; if (g !== 1'b1) begin errors++; $display("FAIL oor_wr_grant: got %b expected 1", g); end
        bus_read(0, 1, 14'd10024, d, lat);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", d); end
        vectors++; if (lat !== 1) begin errors++; $display("FAIL oor_rd_latency: got %0d expected 1", lat); end
        bus_read(0, 1, 14'd0, d, lat);
        vectors++; if (d !== 32'h01020304) begin errors++; $display("FAIL oor_addr0: got %h expected 01020304", d); end
        bus_read(0, 2, 14'd10023, d, lat);
        vectors++; if (d !== 32'h0A0B0C0D) begin errors++; $display("FAIL oor_addr_last: got %h expected 0a0b0c0d", d); end
        bus_read(0, 2, 14'h3FFF, d, lat);
        vectors++; if (d !== 32'h0 || lat !== 1) begin errors++; $display("FAIL oor_top: got %h lat %0d expected 0 lat 1", d, lat); end
    endtask

    task automatic test_fixed_prio;
        logic w1, v1, w2, v2;
        logic [31:0] r1, r2;
        int c1, c2;
        drive(1, 1, 1'b1, 1'b1, 1'b0, 14'd1, 4'hF, 32'h0);
        drive(1, 2, 1'b1, 1'b1, 1'b0, 14'd2, 4'hF, 32'h0);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            sample(1, 1, w1, v1, r1);
            sample(1, 2, w2, v2, r2);
            if (i < 6) begin
                vectors++; if (w1 !== 1'b0) begin errors++; $display("FAIL fp_s1_wait[%0d]: got %b expected 0", i, w1); end
                vectors++; if (w2 !== 1'b1) begin errors++; $display("FAIL fp_s2_wait[%0d]: got %b expected 1", i, w2); end
            end else if (i == 6) begin
                vectors++; if (w2 !== 1'b0) begin errors++; $display("FAIL fp_s2_grant: got wait %b expected 0", w2); end
            end
            if (v1) c1++;
            if (v2) c2++;
            @(posedge clk);
            #1;
            if (i == 5) idle(1, 1);
            if (i == 6) idle(1, 2);
        end
        vectors++; if (c1 !== 6) begin errors++; $display("FAIL fp_s1_count: got %0d expected 6", c1); end
        vectors++; if (c2 !== 1) begin errors++; $display("FAIL fp_s2_count: got %0d expected 1", c2); end
    endtask

    task automatic test_reset_midflight;
        logic g, w, v;
        logic [31:0] d, rd;
        int lat, cnt;
        bus_write(1, 2, 14'd7, 32'hCAFEF00D, 4'hF, g);
        drive(1, 1, 1'b1, 1'b1, 1'b0, 14'd7, 4'hF, 32'h0);
        @(negedge clk);
        vectors++; if (b1.waitrequest !== 1'b0) begin errors++; $display("FAIL mid_grant: got wait %b expected 0", b1.waitrequest); end
        @(posedge clk);
        #1;
        idle(1, 1);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({b1.readdatavalid, b2.readdatavalid, b1.waitrequest, b2.waitrequest} !== 4'b0000 ||
                b1.readdata !== 32'h0 || b2.readdata !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_outputs[%0d]: got v=%b%b w=%b%b d1=%h d2=%h expected all 0", i,
                         b1.readdatavalid, b2.readdatavalid, b1.waitrequest, b2.waitrequest, b1.readdata, b2.readdata);
            end
        end
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample(1, 1, w, v, rd);
            if (v) cnt++;
        end
        vectors++; if (cnt !== 0) begin errors++; $display("FAIL mid_dropped: got %0d pulses expected 0", cnt); end
        @(posedge clk);
        #1;
        bus_read(1, 1, 14'd7, d, lat);
        vectors++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_preserved: got %h expected cafef00d", d); end
        vectors++; if (lat !== 2) begin errors++; $display("FAIL mid_latency: got %0d expected 2", lat); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_round_robin();
        test_out_of_range();
        test_fixed_prio();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
